// File: rtl/elev_pkg.sv
// Shared elevator-board constants: FSM state encodings and the board clock rate.
package elev_pkg;

  localparam int unsigned CLK_HZ = 50000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_e;

endpackage

// File: rtl/led_blink_driver.sv
// Stretches a 1-cycle event pulse into BLINKS visible high/low pairs on one output pin.
module led_blink_driver
  import elev_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = CLK_HZ / 4,
  parameter int unsigned BLINKS      = 3,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned BLK_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  input  logic cancel,
  output logic led,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINKS - 1);

  blink_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [BLK_W-1:0] blk;
  logic             cnt_tc;
  logic             blk_tc;

  assign cnt_tc = (cnt == CNT_LAST);
  assign blk_tc = (blk == BLK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      blk   <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= ST_IDLE;
        cnt   <= '0;
        blk   <= '0;
        led   <= 1'b0;
        busy  <= 1'b0;
      end else if (trig) begin
        // Retrigger restarts from the first blink, even on the final terminal count.
        state <= ST_ON;
        cnt   <= '0;
        blk   <= '0;
        led   <= 1'b1;
        busy  <= 1'b1;
      end else begin
        case (state)
          ST_ON: begin
            if (cnt_tc) begin
              state <= ST_OFF;
              cnt   <= '0;
              led   <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_OFF: begin
            if (cnt_tc) begin
              cnt <= '0;
              if (blk_tc) begin
                state <= ST_IDLE;
                blk   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_ON;
                blk   <= blk + 1'b1;
                led   <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            blk   <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
